data_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the EX/MEM pipeline register and the MEM/WB register of the pipelined core. It serves word loads and stores from the memory stage, and resolves a hit in the same cycle. On a miss it stalls the pipeline through its ready/hit outputs while it writes back any dirty victim line and refills from a 128-bit-wide backing data memory over a req/ack handshake.

---
 rtl/data_cache.sv | 124 ++++++++++++
 tb/tb_data_cache.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// data_cache : direct-mapped, write-back, write-allocate data cache
// Rev 1.0
// ============================================================================
module data_cache #(
  parameter int INDEX_BITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         is_input_valid,
  input  logic [31:0]  addr,
  input  logic         mem_rw,
  input  logic [31:0]  din,
  output logic         is_ready,
  output logic         is_output_valid,
  output logic [31:0]  dout,
  output logic         is_hit,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [127:0] mem_rdata
);
  localparam int c_lines    = 1 << INDEX_BITS;
  localparam int c_tag_bits = 28 - INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_lines-1:0]    r_valid;
  logic [c_lines-1:0]    r_dirty;
  logic [c_tag_bits-1:0] r_tag_mem  [c_lines];
  logic [127:0]          r_data_mem [c_lines];
  logic [INDEX_BITS-1:0] r_idx;
  logic [c_tag_bits-1:0] r_tag;

  logic [INDEX_BITS-1:0] w_idx;
  logic [c_tag_bits-1:0] w_tag;
  logic [1:0]            w_off;
  logic                  w_idle;
  logic                  w_hit;
  logic [127:0]          w_line;
  logic [1:0]            w_unused_addr;

  assign w_idx         = addr[3+INDEX_BITS:4];
  assign w_tag         = addr[31:4+INDEX_BITS];
  assign w_off         = addr[3:2];
  assign w_unused_addr = addr[1:0];
  assign w_idle        = (r_state == ST_IDLE);
  assign w_line        = r_data_mem[w_idx];
  assign w_hit         = is_input_valid & w_idle & r_valid[w_idx] & (r_tag_mem[w_idx] == w_tag);

  assign is_hit          = w_hit;
  assign is_ready        = w_idle;
  assign is_output_valid = w_hit & ~mem_rw;
  assign dout            = is_output_valid ? w_line[w_off*32 +: 32] : 32'd0;

  assign mem_req   = (r_state == ST_WRITEBACK) | (r_state == ST_ALLOCATE);
  assign mem_we    = (r_state == ST_WRITEBACK);
  assign mem_wdata = (r_state == ST_WRITEBACK) ? r_data_mem[r_idx] : 128'd0;

  // Write-back targets the victim's resident tag, refill targets the latched request tag.
  always_comb begin
    mem_addr = 32'd0;
    case (r_state)
      ST_WRITEBACK: mem_addr = {r_tag_mem[r_idx], r_idx, 4'b0000};
      ST_ALLOCATE:  mem_addr = {r_tag, r_idx, 4'b0000};
      default:      mem_addr = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_valid <= '0;
      r_dirty <= '0;
      r_idx   <= '0;
      r_tag   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit && mem_rw) begin
            r_dirty[w_idx] <= 1'b1;
          end else if (is_input_valid && !w_hit) begin
            r_idx   <= w_idx;
            r_tag   <= w_tag;
            r_state <= (r_valid[w_idx] && r_dirty[w_idx]) ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
        ST_WRITEBACK: begin
          if (mem_ack) begin
            r_dirty[r_idx] <= 1'b0;
            r_state        <= ST_ALLOCATE;
          end
        end
        ST_ALLOCATE: begin
          if (mem_ack) begin
            r_valid[r_idx] <= 1'b1;
            r_dirty[r_idx] <= 1'b0;
            r_state        <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (w_hit && mem_rw) begin
      r_data_mem[w_idx][w_off*32 +: 32] <= din;
    end else if (r_state == ST_ALLOCATE && mem_ack) begin
      r_data_mem[r_idx] <= mem_rdata;
      r_tag_mem[r_idx]  <= r_tag;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// tb_data_cache : randomized self-checking bench with a block-level memory model
// Rev 1.0
// ============================================================================
module tb_data_cache;
  logic         clk = 1'b0;
  logic         reset;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_rw;
  logic [31:0]  din;
  logic         is_ready;
  logic         is_output_valid;
  logic [31:0]  dout;
  logic         is_hit;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ack;
  logic [127:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // bmem: backing memory contents; gview: what the program should observe.
  logic [127:0] bmem  [int unsigned];
  logic [127:0] gview [int unsigned];
  bit           rvalid [16];
  bit           rdirty [16];
  int unsigned  rblk   [16];
  logic [31:0]  last_wb_addr;
  logic [127:0] last_wb_data;

  data_cache #(.INDEX_BITS(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .mem_rw          (mem_rw),
    .din             (din),
    .is_ready        (is_ready),
    .is_output_valid (is_output_valid),
    .dout            (dout),
    .is_hit          (is_hit),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void touch(input int unsigned blk);
    logic [127:0] ln;
    if (!bmem.exists(blk)) begin
      for (int w = 0; w < 4; w++) ln[w*32 +: 32] = (blk * 4 + w) ^ 32'h5A5A_0000;
      bmem[blk]  = ln;
      gview[blk] = ln;
    end
  endfunction

  function automatic void model_reset();
    gview = bmem;
    for (int i = 0; i < 16; i++) begin
      rvalid[i] = 1'b0;
      rdirty[i] = 1'b0;
    end
  endfunction

  function automatic logic [127:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_req"},   mem_req, 1'b0);
    chk({tag, "_we"},    mem_we, 1'b0);
    chk({tag, "_maddr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 128'd0);
    chk({tag, "_ready"}, is_ready, 1'b1);
    chk({tag, "_hit"},   is_hit, 1'b0);
    chk({tag, "_ovld"},  is_output_valid, 1'b0);
    chk({tag, "_dout"},  dout, 32'd0);
  endtask

  task automatic access(input bit rw, input logic [31:0] a, input logic [31:0] d, input int lat);
    int unsigned  blk;
    int unsigned  vblk;
    int           idx;
    int           off;
    bit           exp_hit;
    bit           wb;
    logic [127:0] ln;
    blk = a >> 4;
    idx = int'(blk % 16);
    off = int'(a[3:2]);
    touch(blk);
    @(negedge clk);
    is_input_valid = 1'b1;
    mem_rw         = rw;
    addr           = a;
    din            = d;
    exp_hit        = rvalid[idx] && (rblk[idx] == blk);
    #1;
    chk("ready", is_ready, 1'b1);
    chk("hit", is_hit, exp_hit);
    chk("req_idle", mem_req, 1'b0);
    if (!exp_hit) begin
      wb   = rvalid[idx] && rdirty[idx];
      vblk = rblk[idx];
      @(negedge clk);
      if (wb) begin
        for (int c = 1; c <= lat; c++) begin
          #1;
          chk("wb_req", mem_req, 1'b1);
          chk("wb_we", mem_we, 1'b1);
          chk("wb_addr", mem_addr, vblk << 4);
          chk("wb_data", mem_wdata, gview[vblk]);
          chk("wb_stall_hit", is_hit, 1'b0);
          chk("wb_stall_ready", is_ready, 1'b0);
          last_wb_addr = mem_addr;
          last_wb_data = mem_wdata;
          if (c == lat) mem_ack = 1'b1;
          @(negedge clk);
          mem_ack = 1'b0;
        end
        bmem[vblk] = gview[vblk];
        rdirty[idx] = 1'b0;
      end
      for (int c = 1; c <= lat; c++) begin
        #1;
        chk("al_req", mem_req, 1'b1);
        chk("al_we", mem_we, 1'b0);
        chk("al_addr", mem_addr, blk << 4);
        chk("al_stall_hit", is_hit, 1'b0);
        chk("al_stall_dout", dout, 32'd0);
        if (c == lat) begin
          mem_ack   = 1'b1;
          mem_rdata = bmem[blk];
        end
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = rnd_line();
      end
      rvalid[idx] = 1'b1;
      rblk[idx]   = blk;
      rdirty[idx] = 1'b0;
      #1;
      chk("refill_hit", is_hit, 1'b1);
    end
    ln = gview[blk];
    chk("ovalid", is_output_valid, !rw);
    chk("dout", dout, rw ? 32'd0 : ln[off*32 +: 32]);
    if (rw) begin
      ln[off*32 +: 32] = d;
      gview[blk]       = ln;
      rdirty[idx]      = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      is_input_valid = 1'b0;
      addr           = $urandom;
      din            = $urandom;
      mem_rw         = 1'($urandom);
      mem_ack        = 1'($urandom);
      mem_rdata      = rnd_line();
      #1;
      check_quiet("idle");
    end
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b0;
    is_input_valid = 1'b0;
    mem_ack        = 1'b0;
    #1;
    check_quiet("rst");
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic reset_mid_alloc(input logic [31:0] a);
    @(negedge clk);
    is_input_valid = 1'b1;
    mem_rw         = 1'b0;
    addr           = a;
    #1;
    chk("rma_miss", is_hit, 1'b0);
    @(negedge clk);
    #1;
    chk("rma_alloc1_req", mem_req, 1'b1);
    @(negedge clk);
    #1;
    chk("rma_alloc2_req", mem_req, 1'b1);
    reset = 1'b0;
    #1;
    chk("rma_req_drop", mem_req, 1'b0);
    chk("rma_ready", is_ready, 1'b1);
    chk("rma_maddr", mem_addr, 32'd0);
    model_reset();
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = rnd_line();
    @(negedge clk);
    mem_ack        = 1'b0;
    reset          = 1'b1;
    is_input_valid = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    check_quiet("rma_post");
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    is_input_valid = 1'b0;
    mem_rw         = 1'b0;
    addr           = 32'd0;
    din            = 32'd0;
    mem_ack        = 1'b0;
    mem_rdata      = 128'd0;
    model_reset();
    #2;
    check_quiet("por");
    @(negedge clk);
    reset = 1'b1;

    bmem[4]  = {32'h44, 32'h33, 32'h22, 32'h11};
    gview[4] = bmem[4];
    access(1'b0, 32'h0000_0040, 32'd0, 2);
    access(1'b0, 32'h0000_004C, 32'd0, 1);
    access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1);
    access(1'b0, 32'h0000_0144, 32'd0, 2);
    chk("conflict_wb_addr", last_wb_addr, 32'h40);
    chk("conflict_wb_word1", last_wb_data[63:32], 32'hDEAD_BEEF);
    access(1'b1, 32'h0000_0208, 32'h1234_5678, 2);
    access(1'b0, 32'h0000_0208, 32'd0, 1);
    access(1'b0, 32'h0000_0308, 32'd0, 3);
    chk("evict_wb_addr", last_wb_addr, 32'h200);
    chk("evict_wb_word2", last_wb_data[95:64], 32'h1234_5678);
    idle(12);
    access(1'b0, 32'h0000_0144, 32'd0, 1);

    do_reset();
    reset_mid_alloc(32'h0000_0600);
    access(1'b0, 32'h0000_0600, 32'd0, 2);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle($urandom_range(1, 3));
      end else begin
        access(1'($urandom), ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) |
               ($urandom_range(0, 3) << 2), $urandom, $urandom_range(1, 3));
      end
    end

    @(negedge clk);
    is_input_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
